shift_pipe: RTL and testbench
=============================

// Module: shift_pipe
// PURPOSE
//  Parametrised, pipelined barrel shifter for the RV32I execute stage; successor to the combinational 32-bit right shifter.
//  Performs SLL/SRL/SRA/ROR on WIDTH-bit operands over STAGES register stages.
//  Uses a valid/ready handshake with per-stage backpressure, and a flush for squashed instructions.
//  A TAG sideband (e.g. rd index) travels alongside each result.
// PARAMETERS
//  WIDTH    32  operand/result width; power of 2, >= 8
//  STAGES   2   register stages, 1..$clog2(WIDTH); equals latency in cycles
//  TAG_W    5   sideband tag width, >= 1
//  SHAMT_W  (localparam) $clog2(WIDTH)
// PORTS
//  clk_i        in   1        clock, rising edge
//  rst_i        in   1        synchronous reset, active-high
//  flush_i      in   1        squash all in-flight ops
//  in_valid_i   in   1        input op valid
//  in_ready_o   out  1        block accepts input this cycle
//  in_data_i    in   WIDTH    operand
//  in_shamt_i   in   SHAMT_W  shift amount (upper bits of a wider amount are ignored by the caller)
//  in_op_i      in   2        shift_op_e
//  in_tag_i     in   TAG_W    sideband tag
//  out_valid_o  out  1        result valid
//  out_ready_i  in   1        consumer accepts result
//  out_data_o   out  WIDTH    shifted result
//  out_tag_o    out  TAG_W    tag of the op that produced the result
// BEHAVIOUR
//  - Ops: SLL = a << s. SRL = a >> s (zero fill). SRA = $signed(a) >>> s (fill with a[WIDTH-1]). ROR = (a >> s) | (a << (WIDTH-s)); ROR with s = 0 returns a.
//  - Shamt bits are split across stages. Stage k applies amount bits [lo_k..hi_k], with lo_0 = 0.
//    Each stage takes floor(SHAMT_W/STAGES) bits; the first SHAMT_W%STAGES stages take one extra bit.
//    Example: WIDTH=32, STAGES=2 -> stage0 bits[2:0], stage1 bits[4:3].
//  - Each stage register holds {valid, data, remaining shamt, op, tag}. The fill value for SRA comes from the original sign, carried as a bit.
//  - Elastic pipeline: stage k loads when it is empty, or when its contents advance this cycle.
//    advance_last = out_valid_o & out_ready_i. in_ready_o = (stage0 empty | stage0 advances) & ~flush_i.
//    Any bubble collapses in one cycle.
//  - Latency: an op accepted in cycle t appears on out_valid_o in cycle t+STAGES if there is no backpressure.
//    Throughput is 1 op/cycle.
//  - Hold rule: while out_valid_o=1 & out_ready_i=0, out_data_o and out_tag_o are held stable. No stage overwrites a valid, non-advancing stage.
//  - Ordering: results leave in acceptance order. No op is dropped or duplicated except by flush or reset.
//  - flush_i=1: all stage valids clear at the next edge, and no input is accepted that cycle.
//    flush_i wins over a simultaneous in_valid_i or an output handshake. A handshake at out_* in the flush cycle still counts as delivered.
//  - Reset (rst_i=1, sync): all valids go to 0 at the next edge, including mid-operation; data/tag registers are don't-care.
//    During and after reset: out_valid_o=0, out_data_o=0, out_tag_o=0 (data zeroed on reset). in_ready_o=0 while rst_i=1.
//  - out_data_o/out_tag_o are registered, with no combinational path from in_* to out_*.
//    in_ready_o depends combinationally on out_ready_i only through the advance chain.
//  - Illegal parameter values are caught by an elaboration-time $error.
// STRUCTURE
//  - Package shift_pkg:
//    - typedef enum logic [1:0] shift_op_e {SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b10, SH_ROR=2'b11}
//    - function stage_lo(k, SHAMT_W, STAGES)
//  - Sub-module shift_stage #(WIDTH, LO, HI, TAG_W): one combinational partial shift by bits [HI:LO], plus its valid/data register and load/hold logic.
//    shift_pipe instantiates STAGES of them in a generate loop and computes the advance chain.
// TESTING
//  1. SRA 0x8000_0000 by 31 -> 0xFFFF_FFFF; SRL same -> 0x0000_0001; SLL 0x0000_0001 by 31 -> 0x8000_0000. Each at latency STAGES.
//  2. ROR 0x0000_0001 by 1 -> 0x8000_0000; ROR 0xDEAD_BEEF by 0 -> 0xDEAD_BEEF; tag 5'h1F is preserved.
//  3. Backpressure: 4 back-to-back ops with out_ready_i=0 for 5 cycles.
//     -> in_ready_o drops after STAGES ops are buffered; output is held stable; all 4 results then arrive in order with no loss.
//  4. Flush with 2 ops in flight and in_valid_i=1 in the same cycle -> no out_valid_o for those 3 ops; the next op issued after the flush completes normally.
//  5. Assert rst_i while the pipe is full -> next cycle out_valid_o=0, out_data_o=0; the first op after reset release returns the correct result.
//  6. 1000 random ops (random op/shamt/data/tag, random out_ready_i at 70%) against a scoreboard model.
//     Run for WIDTH=32 with STAGES=1,2,5 and for WIDTH=64 with STAGES=3; zero mismatches.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Op encoding and the shift-amount bit split across stages.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROR = 2'b11
    } shift_op_e;

    // Lowest shift-amount bit handled by stage k; the first
    // (shamt_w % stages) stages take one extra bit each.
    function automatic int stage_lo(
        input int k,
        input int shamt_w,
        input int stages
    );
        int base;
        int extra;
        base  = shamt_w / stages;
        extra = shamt_w % stages;
        return k * base + ((k < extra) ? k : extra);
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline slot of the barrel shifter: partial shift by
// amount bits [HI:LO] followed by the slot's elastic register.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LO = 0,
    parameter int HI = 2,
    parameter int TAG_W = 5,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               load_i,
    input  logic               in_valid_i,
    input  logic [WIDTH-1:0]   in_data_i,
    input  logic [SHAMT_W-1:0] in_shamt_i,
    input  logic [1:0]         in_op_i,
    input  logic               in_sign_i,
    input  logic [TAG_W-1:0]   in_tag_i,
    output logic               out_valid_o,
    output logic [WIDTH-1:0]   out_data_o,
    output logic [SHAMT_W-1:0] out_shamt_o,
    output logic [1:0]         out_op_o,
    output logic               out_sign_o,
    output logic [TAG_W-1:0]   out_tag_o
);

    logic [SHAMT_W-1:0] amt;
    logic [WIDTH-1:0]   shifted;

    // Shift by only this slot's amount bits; SRA fills with the
    // original operand sign, carried alongside the data.
    always_comb begin
        amt          = '0;
        amt[HI:LO]   = in_shamt_i[HI:LO];
        shifted      = in_data_i;
        unique case (shift_op_e'(in_op_i))
            SH_SLL: shifted = in_data_i << amt;
            SH_SRL: shifted = in_data_i >> amt;
            SH_SRA: shifted = WIDTH'({{WIDTH{in_sign_i}}, in_data_i} >> amt);
            SH_ROR: shifted = WIDTH'({in_data_i, in_data_i} >> amt);
        endcase
    end

    // Slot register: refills when empty or draining, never
    // overwritten while holding a stalled op.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_shamt_o <= '0;
            out_op_o    <= 2'b00;
            out_sign_o  <= 1'b0;
            out_tag_o   <= '0;
        end else begin
            if (flush_i) begin
                out_valid_o <= 1'b0;
            end else if (load_i) begin
                out_valid_o <= in_valid_i;
            end
            if (load_i && in_valid_i) begin
                out_data_o  <= shifted;
                out_shamt_o <= in_shamt_i;
                out_op_o    <= in_op_i;
                out_sign_o  <= in_sign_i;
                out_tag_o   <= in_tag_i;
            end
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined SLL/SRL/SRA/ROR barrel shifter with valid/ready,
// flush and a tag sideband; latency equals STAGES.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STAGES = 2,
    parameter int TAG_W = 5,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   in_data_i,
    input  logic [SHAMT_W-1:0] in_shamt_i,
    input  logic [1:0]         in_op_i,
    input  logic [TAG_W-1:0]   in_tag_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WIDTH-1:0]   out_data_o,
    output logic [TAG_W-1:0]   out_tag_o
);

    if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("shift_pipe: WIDTH must be a power of 2 >= 8");
    end
    if (STAGES < 1 || STAGES > SHAMT_W) begin : g_bad_stages
        $error("shift_pipe: STAGES must be 1..$clog2(WIDTH)");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("shift_pipe: TAG_W must be >= 1");
    end

    // Index 0 is the input port, index k+1 is slot k's register.
    logic [STAGES:0]    vld;
    logic [WIDTH-1:0]   dat [0:STAGES];
    logic [SHAMT_W-1:0] amt [0:STAGES];
    logic [1:0]         op  [0:STAGES];
    logic               sgn [0:STAGES];
    logic [TAG_W-1:0]   tag [0:STAGES];
    logic [STAGES-1:0]  rdy;

    assign vld[0] = in_valid_i;
    assign dat[0] = in_data_i;
    assign amt[0] = in_shamt_i;
    assign op[0]  = in_op_i;
    assign sgn[0] = in_data_i[WIDTH-1];
    assign tag[0] = in_tag_i;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Slot k can refill if the sink is ready or any slot from
        // k to the output is empty, so bubbles collapse at once.
        assign rdy[k] = out_ready_i | ~(&vld[STAGES:k+1]);

        shift_stage #(
            .WIDTH (WIDTH),
            .LO    (stage_lo(k, SHAMT_W, STAGES)),
            .HI    (stage_lo(k + 1, SHAMT_W, STAGES) - 1),
            .TAG_W (TAG_W)
        ) u_stage (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .flush_i     (flush_i),
            .load_i      (rdy[k] & ~flush_i),
            .in_valid_i  (vld[k]),
            .in_data_i   (dat[k]),
            .in_shamt_i  (amt[k]),
            .in_op_i     (op[k]),
            .in_sign_i   (sgn[k]),
            .in_tag_i    (tag[k]),
            .out_valid_o (vld[k+1]),
            .out_data_o  (dat[k+1]),
            .out_shamt_o (amt[k+1]),
            .out_op_o    (op[k+1]),
            .out_sign_o  (sgn[k+1]),
            .out_tag_o   (tag[k+1])
        );
    end

    assign in_ready_o  = rdy[0] & ~flush_i & ~rst_i;
    assign out_valid_o = vld[STAGES];
    assign out_data_o  = dat[STAGES];
    assign out_tag_o   = tag[STAGES];

endmodule

// File: tb/tb_shift_pipe.sv
// Directed and scoreboard bench for shift_pipe.
// Inputs change 1ns after the rising edge; outputs sampled 2ns after.
module tb_shift_pipe;
    import shift_pkg::*;

    localparam int WIDTH   = 32;
    localparam int STAGES  = 2;
    localparam int TAG_W   = 5;
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_op;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [TAG_W-1:0]   out_tag;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] d;
        int          s;
        logic [4:0]  t;
        logic [31:0] e;
    } vec_t;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [TAG_W-1:0] t;
    } exp_t;

    always #5 clk = ~clk;

    shift_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .TAG_W  (TAG_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_shamt_i  (in_shamt),
        .in_op_i     (in_op),
        .in_tag_i    (in_tag),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_tag_o   (out_tag)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] ref_shift(
        input logic [1:0]         op,
        input logic [WIDTH-1:0]   a,
        input logic [SHAMT_W-1:0] s
    );
        case (op)
            2'b00:   return a << s;
            2'b01:   return a >> s;
            2'b10:   return $signed(a) >>> s;
            default: return (s == 0) ? a : ((a >> s) | (a << (WIDTH - int'(s))));
        endcase
    endfunction

    task automatic run_op(
        input  logic [1:0]         op,
        input  logic [WIDTH-1:0]   d,
        input  logic [SHAMT_W-1:0] s,
        input  logic [TAG_W-1:0]   t,
        output logic [WIDTH-1:0]   r,
        output logic [TAG_W-1:0]   rt,
        output int                 lat
    );
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = op;
        in_data   = d;
        in_shamt  = s;
        in_tag    = t;
        lat = -1;
        r   = '0;
        rt  = '0;
        tick;
        in_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (out_valid) begin
                lat = c;
                r   = out_data;
                rt  = out_tag;
                break;
            end
            tick;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b1;
        in_op = 2'b00;
        in_data = 32'h1234_5678;
        in_shamt = '0;
        in_tag = 5'h3;
        out_ready = 1'b1;
        tick;
        tick;
        checks += 4;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got=%b want=0", out_valid);
        end
        if (out_data !== '0) begin
            errors++;
            $display("FAIL reset_data got=%h want=0", out_data);
        end
        if (out_tag !== '0) begin
            errors++;
            $display("FAIL reset_tag got=%h want=0", out_tag);
        end
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready got=%b want=0", in_ready);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        tick;
        checks += 2;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready got=%b want=1", in_ready);
        end
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_valid got=%b want=0", out_valid);
        end
    endtask

    task automatic test_ops;
        vec_t v[11];
        logic [WIDTH-1:0] r;
        logic [TAG_W-1:0] rt;
        int lat;
        v = '{
            '{2'b10, 32'h8000_0000, 31, 5'h01, 32'hFFFF_FFFF},
            '{2'b01, 32'h8000_0000, 31, 5'h02, 32'h0000_0001},
            '{2'b00, 32'h0000_0001, 31, 5'h03, 32'h8000_0000},
            '{2'b11, 32'h0000_0001,  1, 5'h1F, 32'h8000_0000},
            '{2'b11, 32'hDEAD_BEEF,  0, 5'h04, 32'hDEAD_BEEF},
            '{2'b11, 32'h1234_5678,  8, 5'h05, 32'h7812_3456},
            '{2'b10, 32'h7000_0000,  4, 5'h06, 32'h0700_0000},
            '{2'b10, 32'hF000_0000,  4, 5'h07, 32'hFF00_0000},
            '{2'b00, 32'hDEAD_BEEF,  4, 5'h08, 32'hEADB_EEF0},
            '{2'b01, 32'hDEAD_BEEF, 16, 5'h09, 32'h0000_DEAD},
            '{2'b10, 32'h8000_0000,  0, 5'h0A, 32'h8000_0000}
        };
        foreach (v[i]) begin
            run_op(v[i].op, v[i].d, SHAMT_W'(v[i].s), v[i].t, r, rt, lat);
            checks += 3;
            if (r !== v[i].e) begin
                errors++;
                $display("FAIL op%0d_data got=%h want=%h", i, r, v[i].e);
            end
            if (rt !== v[i].t) begin
                errors++;
                $display("FAIL op%0d_tag got=%h want=%h", i, rt, v[i].t);
            end
            if (lat != STAGES) begin
                errors++;
                $display("FAIL op%0d_latency got=%0d want=%0d", i, lat, STAGES);
            end
        end
        tick;
    endtask

    task automatic test_back_to_back;
        int sent = 0;
        int got = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 30 && got < 4; c++) begin
            in_valid = (sent < 4);
            in_op    = 2'b01;
            in_data  = 32'h0000_0100;
            in_shamt = SHAMT_W'(sent);
            in_tag   = TAG_W'(sent + 10);
            #1;
            if (sent < 4) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready c=%0d got=%b want=1", c, in_ready);
                end
            end
            if (out_valid) begin
                checks += 3;
                if (c != got + STAGES) begin
                    errors++;
                    $display("FAIL b2b_cycle%0d got=%0d want=%0d", got, c, got + STAGES);
                end
                if (out_data !== (32'h100 >> got)) begin
                    errors++;
                    $display("FAIL b2b_data%0d got=%h want=%h", got, out_data, 32'h100 >> got);
                end
                if (out_tag !== TAG_W'(got + 10)) begin
                    errors++;
                    $display("FAIL b2b_tag%0d got=%h want=%h", got, out_tag, got + 10);
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
            tick;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL b2b_count got=%0d want=4", got);
        end
        tick;
    endtask

    task automatic test_backpressure;
        int sent = 0;
        int got = 0;
        logic [WIDTH-1:0] held = '0;
        logic have_held = 1'b0;
        for (int c = 0; c < 60 && got < 4; c++) begin
            out_ready = (c >= 5);
            in_valid  = (sent < 4);
            in_op     = 2'b00;
            in_data   = 32'h0000_0001;
            in_shamt  = SHAMT_W'(sent + 1);
            in_tag    = TAG_W'(sent + 3);
            #1;
            if (c == 4) begin
                checks += 2;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_ready got=%b want=0", in_ready);
                end
                if (sent != STAGES) begin
                    errors++;
                    $display("FAIL bp_buffered got=%0d want=%0d", sent, STAGES);
                end
            end
            if (out_valid && !out_ready) begin
                checks++;
                if (!have_held) begin
                    held = out_data;
                    have_held = 1'b1;
                    if (out_data !== 32'h2) begin
                        errors++;
                        $display("FAIL bp_first got=%h want=00000002", out_data);
                    end
                end else if (out_data !== held) begin
                    errors++;
                    $display("FAIL bp_hold got=%h want=%h", out_data, held);
                end
            end
            if (out_valid && out_ready) begin
                checks += 2;
                if (out_data !== (32'h2 << got)) begin
                    errors++;
                    $display("FAIL bp_data%0d got=%h want=%h", got, out_data, 32'h2 << got);
                end
                if (out_tag !== TAG_W'(got + 3)) begin
                    errors++;
                    $display("FAIL bp_tag%0d got=%h want=%h", got, out_tag, got + 3);
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
            tick;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL bp_count got=%0d want=4", got);
        end
        tick;
    endtask

    task automatic test_flush;
        int seen = 0;
        logic [WIDTH-1:0] r;
        logic [TAG_W-1:0] rt;
        int lat;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_op = 2'b00;
        in_data = 32'h1;
        in_shamt = 5'd1;
        in_tag = 5'd1;
        tick;
        in_shamt = 5'd2;
        in_tag = 5'd2;
        tick;
        in_shamt = 5'd3;
        in_tag = 5'd3;
        flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready got=%b want=0", in_ready);
        end
        tick;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (out_valid) seen++;
            tick;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_leak got=%0d want=0", seen);
        end
        run_op(2'b10, 32'h8000_00F0, 5'd4, 5'd7, r, rt, lat);
        checks += 3;
        if (r !== 32'hF800_000F) begin
            errors++;
            $display("FAIL flush_next_data got=%h want=f800000f", r);
        end
        if (rt !== 5'd7) begin
            errors++;
            $display("FAIL flush_next_tag got=%h want=07", rt);
        end
        if (lat != STAGES) begin
            errors++;
            $display("FAIL flush_next_lat got=%0d want=%0d", lat, STAGES);
        end
        tick;
    endtask

    task automatic test_reset_mid;
        logic [WIDTH-1:0] r;
        logic [TAG_W-1:0] rt;
        int lat;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_op = 2'b11;
        in_data = 32'hA5A5_0F0F;
        in_shamt = 5'd5;
        in_tag = 5'h15;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (!in_ready) break;
            tick;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ready got=%b want=0", in_ready);
        end
        tick;
        checks += 3;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_valid got=%b want=0", out_valid);
        end
        if (out_data !== '0) begin
            errors++;
            $display("FAIL rstmid_data got=%h want=0", out_data);
        end
        if (out_tag !== '0) begin
            errors++;
            $display("FAIL rstmid_tag got=%h want=0", out_tag);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        tick;
        run_op(2'b01, 32'hF0F0_0000, 5'd20, 5'd9, r, rt, lat);
        checks += 3;
        if (r !== 32'h0000_0F0F) begin
            errors++;
            $display("FAIL rstmid_next_data got=%h want=00000f0f", r);
        end
        if (rt !== 5'd9) begin
            errors++;
            $display("FAIL rstmid_next_tag got=%h want=09", rt);
        end
        if (lat != STAGES) begin
            errors++;
            $display("FAIL rstmid_next_lat got=%0d want=%0d", lat, STAGES);
        end
        tick;
    endtask

    task automatic test_random;
        exp_t q[$];
        exp_t e;
        int sent = 0;
        for (int c = 0; c < 20000 && (sent < 1000 || q.size() > 0); c++) begin
            in_valid  = (sent < 1000) && ($urandom_range(0, 9) < 8);
            in_op     = 2'($urandom);
            in_data   = WIDTH'({$urandom, $urandom});
            in_shamt  = SHAMT_W'($urandom);
            in_tag    = TAG_W'($urandom);
            out_ready = ($urandom_range(0, 99) < 70);
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra got=%h want=none", out_data);
                end else begin
                    e = q.pop_front();
                    if (out_data !== e.d || out_tag !== e.t) begin
                        errors++;
                        $display("FAIL rand_result got=%h/%h want=%h/%h",
                                 out_data, out_tag, e.d, e.t);
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back('{d: ref_shift(in_op, in_data, in_shamt), t: in_tag});
                sent++;
            end
            tick;
        end
        in_valid = 1'b0;
        checks++;
        if (sent != 1000 || q.size() != 0) begin
            errors++;
            $display("FAIL rand_drain got=%0d sent %0d pending want=1000 sent 0 pending",
                     sent, q.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_ops;
        test_back_to_back;
        test_backpressure;
        test_flush;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
